// File: rtl/fir_xifu_pkg.sv
// Shared types for the FIR XIFU coprocessor pipeline.
// Covers the EX->WB bundle, WB status, and the CV-X-IF commit/result payloads.
package fir_xifu_pkg;

    localparam int unsigned X_ID_WIDTH_DEF = 4;
    localparam int unsigned WB_DEPTH_DEF   = 2;
    localparam int unsigned WB_CNT_W       = $clog2(WB_DEPTH_DEF) + 1;

    typedef logic [X_ID_WIDTH_DEF-1:0] xid_t;

    typedef struct packed {
        logic        valid;
        xid_t        id;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } fir_xifu_ex2wb_t;

    typedef struct packed {
        logic                busy;
        logic [WB_CNT_W-1:0] count;
    } fir_xifu_wb2ctrl_t;

    typedef struct packed {
        xid_t id;
        logic commit_kill;
    } x_commit_t;

    typedef struct packed {
        xid_t        id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        exc;
        logic [5:0]  exccode;
        logic        err;
        logic        dbg;
    } x_result_t;

    typedef enum logic [1:0] {
        WB_EMPTY,
        WB_WAIT,
        WB_SEND,
        WB_DROP
    } wb_state_e;

endpackage

// File: rtl/fir_xifu_wb_if.sv
// CV-X-IF commit and result channels between core and coprocessor.
// The core side is the master; the coprocessor uses the commit/result views.
interface fir_xifu_wb_if;
    import fir_xifu_pkg::*;

    logic      commit_valid;
    x_commit_t commit;
    logic      result_valid;
    logic      result_ready;
    x_result_t result;

    modport master (
        output commit_valid,
        output commit,
        output result_ready,
        input  result_valid,
        input  result
    );

    modport coproc_commit (
        input commit_valid,
        input commit
    );

    modport coproc_result (
        output result_valid,
        output result,
        input  result_ready
    );

endinterface

// File: rtl/fir_xifu_wb_fifo.sv
// DEPTH-entry synchronous FIFO of completed EX->WB instructions.
// Refuses a push when full even if a pop happens in the same cycle.
module fir_xifu_wb_fifo
    import fir_xifu_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   i_push,
    input  fir_xifu_ex2wb_t        i_data,
    input  logic                   i_pop,
    output fir_xifu_ex2wb_t        o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    fir_xifu_ex2wb_t r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_count;
    logic            w_push;
    logic            w_pop;

    assign o_full  = (r_count == DEPTH[PW:0]);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fir_xifu_wb.sv
// FIR XIFU writeback stage: buffers finished instructions and emits one
// CV-X-IF result per committed instruction in issue order.
module fir_xifu_wb
    import fir_xifu_pkg::*;
#(
    parameter int unsigned DEPTH      = WB_DEPTH_DEF,
    parameter int unsigned X_ID_WIDTH = X_ID_WIDTH_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    fir_xifu_wb_if.coproc_commit        xif_commit_i,
    fir_xifu_wb_if.coproc_result        xif_result_o,
    input  fir_xifu_ex2wb_t             ex2wb_i,
    output logic                        ex2wb_ready_o,
    output fir_xifu_wb2ctrl_t           wb2ctrl_o
);

    localparam int unsigned NID = 2 ** X_ID_WIDTH;

    fir_xifu_ex2wb_t        w_head;
    logic                   w_full;
    logic                   w_empty;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_pop;
    wb_state_e              w_state;
    logic [NID-1:0]         r_commit;
    logic [NID-1:0]         r_kill;

    assign ex2wb_ready_o   = ~w_full;
    assign wb2ctrl_o.count = w_count;
    assign wb2ctrl_o.busy  = (w_count != '0);

    fir_xifu_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (ex2wb_i.valid),
        .i_data  (ex2wb_i),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Head state is a pure function of FIFO and scoreboard contents.
    always_comb begin
        w_state = WB_WAIT;
        if (w_empty) begin
            w_state = WB_EMPTY;
        end else if (r_kill[w_head.id]) begin
            w_state = WB_DROP;
        end else if (r_commit[w_head.id]) begin
            w_state = WB_SEND;
        end
    end

    always_comb begin
        xif_result_o.result_valid = 1'b0;
        xif_result_o.result       = '0;
        w_pop                     = 1'b0;
        unique case (w_state)
            WB_SEND: begin
                xif_result_o.result_valid = 1'b1;
                xif_result_o.result.id    = w_head.id;
                xif_result_o.result.data  = w_head.data;
                xif_result_o.result.rd    = w_head.rd;
                xif_result_o.result.we    = w_head.we;
                w_pop                     = xif_result_o.result_ready;
            end
            WB_DROP: w_pop = 1'b1;
            default: w_pop = 1'b0;
        endcase
    end

    // New commits are applied after the pop clear so a reused id wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_commit <= '0;
            r_kill   <= '0;
        end else begin
            if (w_pop && w_state == WB_SEND) begin
                r_commit[w_head.id] <= 1'b0;
            end
            if (w_pop && w_state == WB_DROP) begin
                r_kill[w_head.id] <= 1'b0;
            end
            if (xif_commit_i.commit_valid) begin
                if (xif_commit_i.commit.commit_kill) begin
                    r_kill[xif_commit_i.commit.id] <= 1'b1;
                end else begin
                    r_commit[xif_commit_i.commit.id] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert ((r_commit & r_kill) == '0)
            else $error("fir_xifu_wb: id both committed and killed");
        end
    end

endmodule

// File: doc/fir_xifu_wb.md
Name: fir_xifu_wb

Overview:
- Writeback/result stage of the FIR XIFU coprocessor. It is the transmitting end of the CV-X-IF result interface, driving results from coprocessor to core.
- Buffers completed XIFU instructions (ldtap/ldsam/stsam) arriving from the EX/MEM stage.
- Tracks commit/kill notifications from the core's commit interface.
- Emits exactly one result transaction per committed instruction, in issue order, and silently drops killed ones.

Parameters:
- DEPTH, 2, result-buffer entries; power of two, at least 2.
- X_ID_WIDTH, 4, width of the XIF instruction id; the commit scoreboard has 2**X_ID_WIDTH entries.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- xif_commit_i  interface  -  cv32e40x_if_xif.coproc_commit; uses commit_valid, commit.id, commit.commit_kill.
- xif_result_o  interface  -  cv32e40x_if_xif.coproc_result; drives result_valid and result.{id,data,rd,we,exc,exccode,err,dbg}; samples result_ready.
- ex2wb_i  input  struct fir_xifu_ex2wb_t  fields: valid, id[X_ID_WIDTH], rd[5], data[32], we.
- ex2wb_ready_o  output  1  buffer can accept a push.
- wb2ctrl_o  output  struct fir_xifu_wb2ctrl_t  fields: busy, count[$clog2(DEPTH)+1].

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - FIFO empty; pointers 0; commit and kill scoreboards all 0.
  - result_valid=0 and all result fields 0.
  - ex2wb_ready_o=1; wb2ctrl_o='0.
- Push:
  - Occurs when ex2wb_i.valid & ex2wb_ready_o.
  - ex2wb_ready_o = !full. There is no pass-through when full, even if a pop happens the same cycle.
- Commit tracking:
  - On commit_valid, set kill[id] if commit_kill, else set commit[id].
  - The scoreboard is registered; the effect is visible to head evaluation the next cycle.
  - A commit may arrive before, during, or after the matching entry is pushed; all three cases are legal.
- Head FSM, states EMPTY, WAIT, SEND, DROP, evaluated on the head entry:
  - EMPTY: FIFO empty; result_valid=0.
  - WAIT: neither commit[head.id] nor kill[head.id] is set; result_valid=0.
  - SEND: commit[head.id] is set.
    - result_valid=1; result.id/data/rd/we come from the head entry.
    - exc, exccode, err and dbg are tied 0.
    - Pop on result_valid & result_ready, which clears commit[head.id].
  - DROP: kill[head.id] is set.
    - One cycle with result_valid=0.
    - Pop and clear kill[head.id].
  - Transitions are derived combinationally from the FIFO and scoreboard state each cycle.
- Minimum latency:
  - Push at cycle N with commit already recorded: result_valid at N+1.
  - Commit at cycle N with entry already at head: result_valid at N+1.
- Handshake:
  - Once result_valid=1, it and the payload stay stable until result_ready.
  - If result_ready is already 1 when result_valid rises, the transfer completes that cycle.
- Ordering: results leave strictly in push order. Killed entries never reach the interface.
- Stores (we=0) still produce a result with we=0 and data passed through unchanged.
- Simultaneous events:
  - Push and pop in the same cycle when not full leave count unchanged.
  - A commit for id X in the same cycle that X's previous entry pops: set-after-clear (the new commit wins).
- Pointers wrap modulo DEPTH.
- wb2ctrl_o.count = occupancy; wb2ctrl_o.busy = (count != 0).
- If a commit and a kill are both set for the same id, behaviour is undefined; an assertion flags it.

Decomposition:
- fir_xifu_pkg gains the fir_xifu_ex2wb_t and fir_xifu_wb2ctrl_t typedefs and the default X_ID_WIDTH constant.
- Sub-module fir_xifu_wb_fifo: a generic DEPTH-entry synchronous FIFO of fir_xifu_ex2wb_t with push/pop/full/empty/count outputs.
- The head FSM and scoreboard stay in fir_xifu_wb.

Test Plan:
- Push {id=3, rd=5, data=0xDEADBEEF, we=1} at cycle 0; commit id=3 at cycle 1 with result_ready=1 → result_valid at cycle 2 with id=3, rd=5, data=0xDEADBEEF, we=1, for exactly 1 cycle; count returns to 0.
- Commit id=7 at cycle 0, push id=7 at cycle 2 → result_valid at cycle 3. Commit id=9 with commit_kill=1, then push id=9 → no result ever; entry dropped within 2 cycles; busy=0.
- DEPTH=2: push ids 1 and 2 with result_ready=0 → ex2wb_ready_o=0 and count=2. A third push is refused and not stored. Commit both, hold result_ready=0 for 5 cycles → result_valid and payload stable (id=1). Raise result_ready → id=1 then id=2 on consecutive cycles.
- Push ids 4,5,6; commit 6 first, then 5, then 4 → results emitted in order 4,5,6 only after id 4 commits.
- Push id=2 (we=0, store); kill id=1 while id 1 sits ahead of id 2; commit id=2 → id 1 silently dropped, then result id=2 with we=0.
- Assert rst_ni=0 mid-SEND while result_ready=0 → result_valid=0 immediately (asynchronous); after release count=0, scoreboards clear; an old commit id does not fire a result for a new push until it is recommitted.
